hybrid_branch_predictor: RTL and testbench
==========================================

Name: hybrid_branch_predictor

Overview:
- Fetch-side predictor upstream of the IF PC mux; drives the predicted-target input and the select condition for the predicted-target path.
- Tournament scheme: bimodal table, gshare table and a chooser table, all 2-bit counters, plus a direct-mapped BTB holding taken targets.
- Lookup is combinational on the current fetch address; training comes from the EX stage once a branch or jump resolves.

Parameters:
INDEX_BITS, 6, log2 entries of the bimodal, gshare and chooser tables; GHR width equals INDEX_BITS
BTB_INDEX_BITS, 4, log2 BTB entries; tag = pc[31:BTB_INDEX_BITS+2]

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
pred_pc  in  32  fetch address being looked up (if_pc)
pred_val  in  1  lookup valid; gates pred_taken
pred_hit  out  1  BTB valid and tag match for pred_pc
pred_taken  out  1  predict redirect to pred_target
pred_target  out  32  BTB target if pred_taken, else pred_pc+4
pred_ghr  out  INDEX_BITS  GHR used for this lookup; carried down the pipe to EX
upd_val  in  1  resolution valid this cycle
upd_pc  in  32  PC of the resolved instruction
upd_is_branch  in  1  conditional branch
upd_is_jump  in  1  JAL/JALR; unconditional
upd_taken  in  1  actual outcome (1 for jumps)
upd_target  in  32  actual taken target
upd_ghr  in  INDEX_BITS  pred_ghr snapshot captured at lookup of this instruction

Behaviour:
- Indexing:
  - bidx = pc[INDEX_BITS+1:2]
  - gidx = pc[INDEX_BITS+1:2] ^ GHR (GHR at lookup, upd_ghr at update)
  - cidx = bidx; btb index = pc[BTB_INDEX_BITS+1:2]
  - pc[1:0] is ignored everywhere.
- Counters: values 0–3; a value >= 2 predicts taken. Chooser >= 2 selects gshare, otherwise bimodal.
- Lookup (combinational, zero latency, reads registered state only):
  - hit = btb_valid & tag match.
  - dir = the chosen table's MSB.
  - pred_taken = pred_val & hit & (btb_is_jump | dir).
  - pred_target = pred_taken ? btb_target : pred_pc+4, computed mod 2^32 (0xFFFFFFFC+4 = 0).
  - pred_ghr = GHR.
- Update (posedge, when upd_val=1):
  - Conditional branch (upd_is_branch):
    - Bimodal[bidx(upd_pc)] and gshare[gidx(upd_pc, upd_ghr)] saturate toward upd_taken: increment if taken, capped at 3; decrement if not taken, floored at 0.
    - Chooser updates only when the pre-update bimodal and gshare MSBs disagree: +1 (sat 3) if gshare was correct, -1 (sat 0) if bimodal was correct.
    - GHR <= {GHR[INDEX_BITS-2:0], upd_taken}.
  - Jumps: never touch counters or GHR.
  - BTB write when upd_taken & (upd_is_branch | upd_is_jump): valid=1, tag, target=upd_target, is_jump=upd_is_jump. This overwrites any entry with a different tag (aliasing replace).
  - Not-taken branches never allocate and leave any existing BTB entry unchanged.
  - If upd_is_branch and upd_is_jump are both set, the update is treated as a jump.
  - upd_val=0: no state change.
- Simultaneous lookup and update to the same entry: the lookup returns pre-update values; there is no bypass. The new state is visible on the next cycle.
- GHR is non-speculative, updated only at resolution. Mispredict recovery is EX's job (pc_sel); the predictor needs no flush input.
- Reset (async, rst=0), effective immediately without a clock edge:
  - All BTB valid bits 0.
  - Bimodal = 1, gshare = 1, chooser = 1 (weakly not-taken / weakly bimodal).
  - GHR = 0.
  - Outputs while in reset or right after: pred_hit=0, pred_taken=0, pred_ghr=0, pred_target=pred_pc+4.
  - Reset asserted mid-stream discards any update in that cycle.

Test Plan:
- Post-reset lookup pred_pc=0x100, pred_val=1 -> pred_hit=0, pred_taken=0, pred_target=0x104, pred_ghr=0.
- Update jump upd_pc=0x200, upd_target=0x380 -> next cycle lookup 0x200: pred_hit=1, pred_taken=1, pred_target=0x380; GHR stays 0, counters unchanged.
- Branch 0x300, taken, target 0x280, upd_ghr=0 -> bimodal[0]=2, gshare[0]=2, chooser stays 1 (both predicted NT), GHR=000001; lookup 0x300 -> pred_taken=1, pred_target=0x280. Repeat with pred_val=0 -> pred_taken=0, pred_hit=1.
- Then 4 not-taken updates at 0x300 -> bimodal[0] reaches 0 with no underflow; BTB entry retained; lookup 0x300 -> pred_hit=1, pred_taken=0, pred_target=0x304.
- Branch 0x400 alternating T,N for 40 resolutions, upd_ghr fed back from pred_ghr -> chooser[0] saturates at 3; the last 16 lookups predict the outcome correctly 16/16.
- Same-cycle lookup and update of 0x500 (first taken) -> that cycle pred_hit=0, next cycle pred_hit=1. Then pull rst low between clock edges -> pred_hit and pred_taken drop to 0 immediately and pred_ghr=0.

Source files
------------

// File: rtl/hybrid_branch_predictor.sv
// rtl/hybrid_branch_predictor.sv - tournament (bimodal/gshare/chooser) predictor with direct-mapped BTB
module hybrid_branch_predictor #(
  parameter int INDEX_BITS     = 6,
  parameter int BTB_INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pred_pc,
  input  logic                  pred_val,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [31:0]           pred_target,
  output logic [INDEX_BITS-1:0] pred_ghr,
  input  logic                  upd_val,
  input  logic [31:0]           upd_pc,
  input  logic                  upd_is_branch,
  input  logic                  upd_is_jump,
  input  logic                  upd_taken,
  input  logic [31:0]           upd_target,
  input  logic [INDEX_BITS-1:0] upd_ghr
);
  localparam int ENTRIES     = 1 << INDEX_BITS;
  localparam int BTB_ENTRIES = 1 << BTB_INDEX_BITS;
  localparam int TAG_BITS    = 30 - BTB_INDEX_BITS;

  logic [1:0]            bimodal [ENTRIES];
  logic [1:0]            gshare  [ENTRIES];
  logic [1:0]            chooser [ENTRIES];
  logic [INDEX_BITS-1:0] ghr;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [BTB_ENTRIES-1:0] btb_is_jump;
  logic [TAG_BITS-1:0]    btb_tag    [BTB_ENTRIES];
  logic [31:0]            btb_target [BTB_ENTRIES];

  function automatic logic [1:0] sat(input logic [1:0] c, input logic up);
    if (up) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  // Lookup: purely combinational on registered state, no update bypass
  logic [INDEX_BITS-1:0]     l_bidx, l_gidx;
  logic [BTB_INDEX_BITS-1:0] l_eidx;
  logic                      l_dir;

  assign l_bidx = pred_pc[INDEX_BITS+1:2];
  assign l_gidx = l_bidx ^ ghr;
  assign l_eidx = pred_pc[BTB_INDEX_BITS+1:2];
  assign l_dir  = chooser[l_bidx][1] ? gshare[l_gidx][1] : bimodal[l_bidx][1];

  assign pred_hit    = btb_valid[l_eidx] && (btb_tag[l_eidx] == pred_pc[31:BTB_INDEX_BITS+2]);
  assign pred_taken  = pred_val && pred_hit && (btb_is_jump[l_eidx] || l_dir);
  assign pred_target = pred_taken ? btb_target[l_eidx] : pred_pc + 32'd4;
  assign pred_ghr    = ghr;

  logic [INDEX_BITS-1:0]     u_bidx, u_gidx;
  logic [BTB_INDEX_BITS-1:0] u_eidx;
  logic                      u_branch;
  logic [1:0]                u_bim, u_gsh;

  assign u_bidx   = upd_pc[INDEX_BITS+1:2];
  assign u_gidx   = u_bidx ^ upd_ghr;
  assign u_eidx   = upd_pc[BTB_INDEX_BITS+1:2];
  // A resolution flagged as both branch and jump trains as a jump only
  assign u_branch = upd_is_branch && !upd_is_jump;
  assign u_bim    = bimodal[u_bidx];
  assign u_gsh    = gshare[u_gidx];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[1:0], upd_pc[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr         <= '0;
      btb_valid   <= '0;
      btb_is_jump <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        bimodal[i] <= 2'd1;
        gshare[i]  <= 2'd1;
        chooser[i] <= 2'd1;
      end
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (upd_val) begin
      if (u_branch) begin
        bimodal[u_bidx] <= sat(u_bim, upd_taken);
        gshare[u_gidx]  <= sat(u_gsh, upd_taken);
        if (u_bim[1] != u_gsh[1])
          chooser[u_bidx] <= sat(chooser[u_bidx], u_gsh[1] == upd_taken);
        ghr <= {ghr[INDEX_BITS-2:0], upd_taken};
      end
      if (upd_taken && (upd_is_branch || upd_is_jump)) begin
        btb_valid[u_eidx]   <= 1'b1;
        btb_is_jump[u_eidx] <= upd_is_jump;
        btb_tag[u_eidx]     <= upd_pc[31:BTB_INDEX_BITS+2];
        btb_target[u_eidx]  <= upd_target;
      end
    end
  end
endmodule

// File: tb/tb_hybrid_branch_predictor.sv
// tb/tb_hybrid_branch_predictor.sv - directed bench with a table-level predictor model
module tb_hybrid_branch_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_val;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic [5:0]  pred_ghr;
  logic        upd_val, upd_is_branch, upd_is_jump, upd_taken;
  logic [31:0] upd_pc, upd_target;
  logic [5:0]  upd_ghr;

  int checks = 0;
  int failures = 0;

  hybrid_branch_predictor dut (
    .clk(clk), .rst(rst),
    .pred_pc(pred_pc), .pred_val(pred_val), .pred_hit(pred_hit),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
    .upd_val(upd_val), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_ghr(upd_ghr)
  );

  always #5 clk = ~clk;

  // Model: counters as plain ints, BTB remembers the full resolved PC
  int          bim_m [64];
  int          gsh_m [64];
  int          cho_m [64];
  int          ghr_m;
  bit          btb_v [16];
  bit          btb_j [16];
  logic [31:0] btb_pc [16];
  logic [31:0] btb_tg [16];

  function automatic int step_ctr(int c, bit up);
    if (up) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int e = int'((pc >> 2) % 16);
    return btb_v[e] && (btb_pc[e] >> 2) == (pc >> 2);
  endfunction

  function automatic bit m_taken(logic [31:0] pc, bit val);
    int e  = int'((pc >> 2) % 16);
    int bi = int'((pc >> 2) % 64);
    int c  = (cho_m[bi] >= 2) ? gsh_m[bi ^ ghr_m] : bim_m[bi];
    return val && m_hit(pc) && (btb_j[e] || c >= 2);
  endfunction

  function automatic logic [31:0] m_target(logic [31:0] pc, bit val);
    return m_taken(pc, val) ? btb_tg[int'((pc >> 2) % 16)] : pc + 32'd4;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_m <= 0;
      for (int i = 0; i < 64; i++) begin
        bim_m[i] <= 1; gsh_m[i] <= 1; cho_m[i] <= 1;
      end
      for (int i = 0; i < 16; i++) btb_v[i] <= 1'b0;
    end else if (upd_val) begin
      if (upd_is_branch && !upd_is_jump) begin
        bim_m[int'((upd_pc >> 2) % 64)] <= step_ctr(bim_m[int'((upd_pc >> 2) % 64)], upd_taken);
        gsh_m[int'((upd_pc >> 2) % 64) ^ int'(upd_ghr)] <=
          step_ctr(gsh_m[int'((upd_pc >> 2) % 64) ^ int'(upd_ghr)], upd_taken);
        if ((bim_m[int'((upd_pc >> 2) % 64)] >= 2) != (gsh_m[int'((upd_pc >> 2) % 64) ^ int'(upd_ghr)] >= 2))
          cho_m[int'((upd_pc >> 2) % 64)] <= step_ctr(cho_m[int'((upd_pc >> 2) % 64)],
            (gsh_m[int'((upd_pc >> 2) % 64) ^ int'(upd_ghr)] >= 2) == upd_taken);
        ghr_m <= ((ghr_m * 2) + int'(upd_taken)) % 64;
      end
      if (upd_taken && (upd_is_branch || upd_is_jump)) begin
        btb_v[int'((upd_pc >> 2) % 16)]  <= 1'b1;
        btb_j[int'((upd_pc >> 2) % 16)]  <= upd_is_jump;
        btb_pc[int'((upd_pc >> 2) % 16)] <= upd_pc;
        btb_tg[int'((upd_pc >> 2) % 16)] <= upd_target;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_hit",    32'(pred_hit),   32'(m_hit(pred_pc)));
    chk("cyc_taken",  32'(pred_taken), 32'(m_taken(pred_pc, pred_val)));
    chk("cyc_target", pred_target,     m_target(pred_pc, pred_val));
    chk("cyc_ghr",    32'(pred_ghr),   32'(ghr_m));
  end

  task automatic look(logic [31:0] pc, logic val);
    pred_pc = pc; pred_val = val;
    @(negedge clk); #1;
  endtask

  task automatic upd(logic [31:0] pc, bit br, bit j, bit t, logic [31:0] tgt);
    upd_val = 1'b1; upd_pc = pc; upd_is_branch = br; upd_is_jump = j;
    upd_taken = t; upd_target = tgt; upd_ghr = pred_ghr;
    @(posedge clk); #2;
    upd_val = 1'b0;
  endtask

  int correct;

  initial begin
    rst = 1'b0; pred_pc = 32'h0; pred_val = 1'b0; upd_val = 1'b0; upd_pc = 32'h0;
    upd_is_branch = 1'b0; upd_is_jump = 1'b0; upd_taken = 1'b0;
    upd_target = 32'h0; upd_ghr = 6'h0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    look(32'h100, 1'b1);
    chk("reset_hit", 32'(pred_hit), 32'h0);
    chk("reset_taken", 32'(pred_taken), 32'h0);
    chk("reset_target", pred_target, 32'h104);
    chk("reset_ghr", 32'(pred_ghr), 32'h0);
    look(32'hFFFF_FFFC, 1'b1);
    chk("wrap_target", pred_target, 32'h0);

    @(posedge clk); #2;
    upd(32'h200, 1'b0, 1'b1, 1'b1, 32'h380);
    look(32'h200, 1'b1);
    chk("jump_hit", 32'(pred_hit), 32'h1);
    chk("jump_taken", 32'(pred_taken), 32'h1);
    chk("jump_target", pred_target, 32'h380);
    chk("jump_ghr", 32'(pred_ghr), 32'h0);

    @(posedge clk); #2;
    upd(32'h300, 1'b1, 1'b0, 1'b1, 32'h280);
    look(32'h300, 1'b1);
    chk("br_taken", 32'(pred_taken), 32'h1);
    chk("br_target", pred_target, 32'h280);
    chk("br_ghr", 32'(pred_ghr), 32'h1);
    chk("model_bim0", 32'(bim_m[0]), 32'd2);
    chk("model_cho0", 32'(cho_m[0]), 32'd1);
    look(32'h300, 1'b0);
    chk("noval_taken", 32'(pred_taken), 32'h0);
    chk("noval_hit", 32'(pred_hit), 32'h1);
    look(32'h200, 1'b1);
    chk("alias_evict_hit", 32'(pred_hit), 32'h0);

    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) upd(32'h300, 1'b1, 1'b0, 1'b0, 32'h999);
    look(32'h300, 1'b1);
    chk("nt_hit", 32'(pred_hit), 32'h1);
    chk("nt_taken", 32'(pred_taken), 32'h0);
    chk("nt_target", pred_target, 32'h304);
    chk("model_bim0_floor", 32'(bim_m[0]), 32'd0);

    @(posedge clk); #2;
    correct = 0;
    for (int i = 0; i < 40; i++) begin
      pred_pc = 32'h400; pred_val = 1'b1;
      upd_val = 1'b1; upd_pc = 32'h400; upd_is_branch = 1'b1; upd_is_jump = 1'b0;
      upd_taken = (i % 2 == 0); upd_target = 32'h480; upd_ghr = pred_ghr;
      @(negedge clk); #1;
      if (i >= 24 && pred_taken === upd_taken) correct++;
      @(posedge clk); #2;
    end
    upd_val = 1'b0;
    chk("alt_last16", 32'(correct), 32'd16);
    chk("model_cho0_sat", 32'(cho_m[0]), 32'd3);

    pred_pc = 32'h500; pred_val = 1'b1;
    upd_val = 1'b1; upd_pc = 32'h500; upd_is_branch = 1'b1; upd_is_jump = 1'b0;
    upd_taken = 1'b1; upd_target = 32'h600; upd_ghr = pred_ghr;
    @(negedge clk); #1;
    chk("same_cyc_hit", 32'(pred_hit), 32'h0);
    @(posedge clk); #2;
    upd_val = 1'b0;
    @(negedge clk); #1;
    chk("next_cyc_hit", 32'(pred_hit), 32'h1);

    rst = 1'b0;
    #1;
    chk("async_hit", 32'(pred_hit), 32'h0);
    chk("async_taken", 32'(pred_taken), 32'h0);
    chk("async_ghr", 32'(pred_ghr), 32'h0);
    chk("async_target", pred_target, 32'h504);
    upd_val = 1'b1; upd_pc = 32'h700; upd_is_branch = 1'b0; upd_is_jump = 1'b1;
    upd_taken = 1'b1; upd_target = 32'h7F0;
    @(posedge clk); #2;
    upd_val = 1'b0;
    rst = 1'b1;
    look(32'h700, 1'b1);
    chk("reset_discard_hit", 32'(pred_hit), 32'h0);
    chk("reset_discard_target", pred_target, 32'h704);

    @(posedge clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
